// File: rtl/decode_pkg.sv
// Shared opcode, sign-extender and ALU encodings for the LEGv8 decode stage.
package decode_pkg;

  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [9:0]  OP_ADDI = 10'h244;
  localparam logic [9:0]  OP_SUBI = 10'h344;
  localparam logic [8:0]  OP_MOVZ = 9'h1A5;
  localparam logic [7:0]  OP_CBZ  = 8'hB4;
  localparam logic [5:0]  OP_B    = 6'h05;

  localparam logic [2:0] SE_I    = 3'b000;
  localparam logic [2:0] SE_D    = 3'b001;
  localparam logic [2:0] SE_B    = 3'b010;
  localparam logic [2:0] SE_CBZ  = 3'b011;
  localparam logic [2:0] SE_MOVZ = 3'b100;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  typedef struct packed {
    logic [2:0] sign_op;
    logic       reg2loc;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       uncond_branch;
    logic [3:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational LEGv8 opcode decoder: instruction word to control bundle and illegal flag.
module instr_decoder
  import decode_pkg::*;
#(
  parameter bit ILLEGAL_AS_NOP = 1'b1
) (
  input  logic [31:0] instr_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [10:0] op11;
  logic [9:0]  op10;
  logic [8:0]  op9;
  logic [7:0]  op8;
  logic [5:0]  op6;

  assign op11 = instr_i[31:21];
  assign op10 = instr_i[31:22];
  assign op9  = instr_i[31:23];
  assign op8  = instr_i[31:24];
  assign op6  = instr_i[31:26];

  // Widest opcode field is tested first so shorter prefixes cannot shadow it.
  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    if (op11 == OP_LDUR) begin
      ctrl_o.sign_op    = SE_D;
      ctrl_o.alu_src    = 1'b1;
      ctrl_o.mem_to_reg = 1'b1;
      ctrl_o.reg_write  = 1'b1;
      ctrl_o.mem_read   = 1'b1;
      ctrl_o.alu_op     = ALU_ADD;
    end else if (op11 == OP_STUR) begin
      ctrl_o.sign_op   = SE_D;
      ctrl_o.reg2loc   = 1'b1;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.mem_write = 1'b1;
      ctrl_o.alu_op    = ALU_ADD;
    end else if (op11 == OP_ADD) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_ADD;
    end else if (op11 == OP_SUB) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_SUB;
    end else if (op11 == OP_AND) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_AND;
    end else if (op11 == OP_ORR) begin
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_ORR;
    end else if (op10 == OP_ADDI || op10 == OP_SUBI) begin
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = (op10 == OP_ADDI) ? ALU_ADD : ALU_SUB;
    end else if (op9 == OP_MOVZ) begin
      ctrl_o.sign_op   = SE_MOVZ;
      ctrl_o.alu_src   = 1'b1;
      ctrl_o.reg_write = 1'b1;
      ctrl_o.alu_op    = ALU_PASSB;
    end else if (op8 == OP_CBZ) begin
      ctrl_o.sign_op = SE_CBZ;
      ctrl_o.reg2loc = 1'b1;
      ctrl_o.branch  = 1'b1;
      ctrl_o.alu_op  = ALU_PASSB;
    end else if (op6 == OP_B) begin
      ctrl_o.sign_op       = SE_B;
      ctrl_o.uncond_branch = 1'b1;
    end else begin
      illegal_o = 1'b1;
      if (ILLEGAL_AS_NOP) begin
        ctrl_o = '0;
      end else begin
        ctrl_o = 'x;
      end
      ctrl_o.sign_op = SE_I;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// IF/ID pipeline register with valid/ready handshake and opcode decode.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned PC_W           = 64,
  parameter bit          ILLEGAL_AS_NOP = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [4:0]      rn,
  output logic [4:0]      rm,
  output logic [4:0]      rd,
  output logic [25:0]     imm26,
  output logic [2:0]      sign_op,
  output logic            reg2loc,
  output logic            alu_src,
  output logic            mem_to_reg,
  output logic            reg_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            branch,
  output logic            uncond_branch,
  output logic [3:0]      alu_op,
  output logic            illegal_o
);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  ctrl_t           ctrl_q;
  logic            illegal_q;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc_q;
  logic            accept;

  instr_decoder #(
    .ILLEGAL_AS_NOP(ILLEGAL_AS_NOP)
  ) u_instr_decoder (
    .instr_i  (in_instr),
    .ctrl_o   (dec_ctrl),
    .illegal_o(dec_illegal)
  );

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Data is only loaded on accept, so bubbles keep the last decoded payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      pc_q      <= '0;
      ctrl_q    <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        instr_q   <= in_instr;
        pc_q      <= in_pc;
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
      end
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign rd         = instr_q[4:0];
  assign rn         = instr_q[9:5];
  assign rm         = instr_q[20:16];
  assign imm26      = instr_q[25:0];
  assign sign_op    = ctrl_q.sign_op;
  assign reg2loc    = ctrl_q.reg2loc;
  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_read   = ctrl_q.mem_read;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal_o  = illegal_q;

  // State-changing controls are masked so a stale payload can never commit.
  assign reg_write     = ctrl_q.reg_write && valid_q;
  assign mem_write     = ctrl_q.mem_write && valid_q;
  assign branch        = ctrl_q.branch && valid_q;
  assign uncond_branch = ctrl_q.uncond_branch && valid_q;

endmodule
